// File: rtl/imem_loader.sv
// imem_loader: byte-stream loader for the core's instruction memory.
// Accepts a 16-bit little-endian word count followed by that many
// little-endian 32-bit words, writes them from word address 0 upward and
// holds the core in reset until the whole image has been written.
//
// Stream handshake: a byte transfers on a rising clk edge where
// s_valid && s_ready. s_ready depends only on the FSM state, never on s_valid,
// so a source may hold s_valid/s_data for as long as s_ready is low.
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR0  = 3'd1,
    HDR1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  // Header arithmetic is done at 17 bits so DEPTH up to 65536 compares cleanly.
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t                state;
  logic [7:0]            n_lo;
  logic [15:0]           n_words;
  logic [ADDR_WIDTH:0]   word_idx;
  logic [1:0]            byte_idx;
  logic [23:0]           word_buf;

  logic                  accept;
  logic [16:0]           n_hdr;
  logic [16:0]           last_idx;
  logic [16:0]           word_idx_ext;

  // Byte transfer qualifier and header/word-index arithmetic.
  assign accept       = s_valid && s_ready;
  assign n_hdr        = {1'b0, s_data, n_lo};
  assign last_idx     = {1'b0, n_words} - 17'd1;
  assign word_idx_ext = 17'(word_idx);

  // Status outputs are pure decodes of the state register.
  assign s_ready    = (state == HDR0) || (state == HDR1) || (state == DATA);
  assign busy       = (state == HDR0) || (state == HDR1) || (state == DATA) || (state == WRITE);
  assign done       = (state == DONE);
  assign err        = (state == ERR);
  assign core_rst_n = (state == DONE);

  // Load sequencer: header capture, byte assembly and one write pulse per word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      n_lo       <= '0;
      n_words    <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) state <= HDR0;
        end
        HDR0: begin
          if (accept) begin
            n_lo  <= s_data;
            state <= HDR1;
          end
        end
        HDR1: begin
          if (accept) begin
            n_words  <= n_hdr[15:0];
            word_idx <= '0;
            byte_idx <= '0;
            if (n_hdr == 17'd0)       state <= DONE;
            else if (n_hdr > DEPTH_W) state <= ERR;
            else                      state <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= s_data;
              2'd1: word_buf[15:8]  <= s_data;
              2'd2: word_buf[23:16] <= s_data;
              default: begin
                // Fourth byte completes the word: present it to memory next cycle.
                imem_we    <= 1'b1;
                imem_addr  <= word_idx[ADDR_WIDTH-1:0];
                imem_wdata <= {s_data, word_buf};
                state      <= WRITE;
              end
            endcase
          end
        end
        WRITE: begin
          if (word_idx_ext == last_idx) begin
            state <= DONE;
          end else begin
            word_idx <= word_idx + (ADDR_WIDTH+1)'(1);
            byte_idx <= '0;
            state    <= DATA;
          end
        end
        DONE, ERR: begin
          if (start) state <= HDR0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
